// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg
//   Shared types and constants for the mult8s product accumulator.
//   - state_e      : accumulator FSM states (ST_ACC, ST_DONE)
//   - DEF_PROD_W   : default product width (signed)
//   - DEF_ACC_W    : default accumulator / result width
//   - DEF_CNT_W    : default product-count width
//   - add_ovf()    : signed-add overflow detect, used by the saturating adder
//                    to decide when to clamp
package mult_acc_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // A signed add overflows only when both operands share a sign and the
  // result's sign differs from it.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/mult_acc_sat_add.sv
// mult_acc_sat_add
//   Combinational ACC_W-bit signed adder for the product accumulator.
//   Build option MULT_ACC_SAT_EN: when defined, an overflowing sum is clamped
//   to the most positive / most negative value and ovf_o flags it; when
//   undefined the sum wraps (two's complement) and no clamp logic exists.
// Ports:
//   a_i   : running accumulator value
//   b_i   : sign-extended product
//   sum_o : a_i + b_i (clamped when saturation is enabled)
//   ovf_o : overflow occurred (only present with MULT_ACC_SAT_EN)
module mult_acc_sat_add
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
`ifdef MULT_ACC_SAT_EN
  output logic             ovf_o,
`endif
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] raw_sum;
  assign raw_sum = a_i + b_i;

`ifdef MULT_ACC_SAT_EN
  logic [ACC_W-1:0] max_pos;
  logic [ACC_W-1:0] max_neg;

  assign max_pos = {1'b0, {(ACC_W-1){1'b1}}};
  assign max_neg = {1'b1, {(ACC_W-1){1'b0}}};
  assign ovf_o   = add_ovf(a_i[ACC_W-1], b_i[ACC_W-1], raw_sum[ACC_W-1]);

  // On overflow both operands share a sign, so a_i's sign picks the rail.
  always_comb begin
    sum_o = raw_sum;
    if (ovf_o) begin
      sum_o = a_i[ACC_W-1] ? max_neg : max_pos;
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/mult8s_product_accumulator.sv
// mult8s_product_accumulator
//   Accumulates a stream of signed products into groups closed by in_last and
//   presents each group's sum and product count on an output handshake.
//   Build option MULT_ACC_SAT_EN: saturating accumulation with a sticky
//   out_sat flag; when undefined the accumulator wraps and out_sat is 0.
// Handshakes: a beat moves on a rising clk edge where valid && ready are both
//   high; the sender holds its data stable while valid is high and ready is
//   low; ready never depends combinationally on the other side's valid.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : product input handshake (in_ready = state is ACC)
//   in_product, in_last  : signed product, group-closing marker
//   out_valid/out_ready  : result output handshake (out_valid = state is DONE)
//   out_sum, out_count   : registered group sum and saturating product count
//   out_sat              : accumulator clamped during the reported group
//   dbg_state            : current FSM state, for observation only
module mult8s_product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output state_e            dbg_state
);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_count_q;
  logic [ACC_W-1:0] prod_ext;
  logic             in_xfer;

  assign in_xfer  = in_valid && (state_q == ST_ACC);
  assign prod_ext = ACC_W'(signed'(in_product));

  // Count sticks at all-ones instead of wrapping back to zero.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MULT_ACC_SAT_EN
  logic sat_q;
  logic sat_d;
  logic out_sat_q;
  logic add_ovf_w;

  mult_acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .ovf_o (add_ovf_w),
    .sum_o (acc_d)
  );

  assign sat_d   = sat_q | add_ovf_w;
  assign out_sat = out_sat_q;
`else
  mult_acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (acc_d)
  );

  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
`ifdef MULT_ACC_SAT_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
`ifdef MULT_ACC_SAT_EN
            sat_q <= sat_d;
`endif
            if (in_last) begin
              // Result includes the closing product itself.
              out_sum_q   <= acc_d;
              out_count_q <= cnt_d;
`ifdef MULT_ACC_SAT_EN
              out_sat_q   <= sat_d;
`endif
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Result registers hold their value; only the group state clears.
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MULT_ACC_SAT_EN
            sat_q   <= 1'b0;
`endif
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult8s_product_accumulator.sv
// tb_mult8s_product_accumulator
//   Directed bench. Three instances share one input stream: a default build
//   (u_dut), a 16-bit accumulator build (u_acc16) for overflow behaviour and a
//   2-bit count build (u_cnt2) for count saturation. Inputs change #1 after
//   the rising edge and outputs are sampled there too.
module tb_mult8s_product_accumulator;
  import mult_acc_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_product;
  logic        in_last;
  logic        out_ready;

  logic        iready_a, ovalid_a, sat_a;
  logic [31:0] sum_a;
  logic [7:0]  cnt_a;
  state_e      dbg_a;

  logic        iready_b, ovalid_b, sat_b;
  logic [15:0] sum_b;
  logic [7:0]  cnt_b;
  state_e      dbg_b;

  logic        iready_c, ovalid_c, sat_c;
  logic [31:0] sum_c;
  logic [1:0]  cnt_c;
  state_e      dbg_c;

  int n_checks;
  int n_pass;

  mult8s_product_accumulator u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready_a),
    .in_product(in_product), .in_last(in_last), .out_valid(ovalid_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_count(cnt_a),
    .out_sat(sat_a), .dbg_state(dbg_a)
  );

  mult8s_product_accumulator #(.ACC_W(16)) u_acc16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready_b),
    .in_product(in_product), .in_last(in_last), .out_valid(ovalid_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_count(cnt_b),
    .out_sat(sat_b), .dbg_state(dbg_b)
  );

  mult8s_product_accumulator #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready_c),
    .in_product(in_product), .in_last(in_last), .out_valid(ovalid_c),
    .out_ready(out_ready), .out_sum(sum_c), .out_count(cnt_c),
    .out_sat(sat_c), .dbg_state(dbg_c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: one product beat, accepted on the next rising edge.
  task automatic send(input logic [15:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  // With out_ready high, the DONE handshake completes on this edge.
  task automatic close_group();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (iready_a !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", iready_a); else n_pass++;
    n_checks++; if (ovalid_a !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", ovalid_a); else n_pass++;
    n_checks++; if (sum_a !== 32'd0) $display("FAIL rst_out_sum: got %0d want 0", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd0) $display("FAIL rst_out_count: got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (sat_a !== 1'b0) $display("FAIL rst_out_sat: got %0b want 0", sat_a); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;

    // Leave a nonzero result behind so the mid-group reset has something to clear.
    send(16'd2, 1'b1);
    n_checks++; if (sum_a !== 32'd2) $display("FAIL pre_sum: got %0d want 2", sum_a); else n_pass++;
    close_group();

    send(16'd9, 1'b0);
    send(16'd9, 1'b0);
    send(16'd9, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++; if (sum_a !== 32'd0) $display("FAIL mid_rst_sum: got %0d want 0", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd0) $display("FAIL mid_rst_count: got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (iready_a !== 1'b1) $display("FAIL mid_rst_in_ready: got %0b want 1", iready_a); else n_pass++;
    n_checks++; if (ovalid_a !== 1'b0) $display("FAIL mid_rst_out_valid: got %0b want 0", ovalid_a); else n_pass++;
    n_checks++; if (dbg_a !== ST_ACC) $display("FAIL mid_rst_state: got %0d want %0d", dbg_a, ST_ACC); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;

    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    n_checks++; if (sum_a !== 32'd12) $display("FAIL post_rst_sum: got %0d want 12", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd2) $display("FAIL post_rst_count: got %0d want 2", cnt_a); else n_pass++;
    close_group();
  endtask

  task automatic test_max_positive();
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b0);
    n_checks++; if (ovalid_a !== 1'b0) $display("FAIL maxpos_early_valid: got %0b want 0", ovalid_a); else n_pass++;
    send(16'h4000, 1'b1);
    n_checks++; if (ovalid_a !== 1'b1) $display("FAIL maxpos_out_valid: got %0b want 1", ovalid_a); else n_pass++;
    n_checks++; if (iready_a !== 1'b0) $display("FAIL maxpos_in_ready: got %0b want 0", iready_a); else n_pass++;
    n_checks++; if (sum_a !== 32'd65536) $display("FAIL maxpos_sum: got %0d want 65536", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd4) $display("FAIL maxpos_count: got %0d want 4", cnt_a); else n_pass++;
    n_checks++; if (dbg_a !== ST_DONE) $display("FAIL maxpos_state: got %0d want %0d", dbg_a, ST_DONE); else n_pass++;
    close_group();
    n_checks++; if (iready_a !== 1'b1) $display("FAIL maxpos_ready_back: got %0b want 1", iready_a); else n_pass++;
    n_checks++; if (ovalid_a !== 1'b0) $display("FAIL maxpos_valid_drop: got %0b want 0", ovalid_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'h8100, 1'b0);   // -32512
    send(16'h0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      // Stray beats while stalled must not be absorbed.
      in_valid   = 1'b1;
      in_product = 16'd100;
      in_last    = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (sum_a !== 32'hFFFF8101) $display("FAIL bp_sum[%0d]: got %0d want -32511", i, $signed(sum_a)); else n_pass++;
      n_checks++; if (cnt_a !== 8'd2) $display("FAIL bp_count[%0d]: got %0d want 2", i, cnt_a); else n_pass++;
      n_checks++; if (iready_a !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, iready_a); else n_pass++;
      n_checks++; if (ovalid_a !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, ovalid_a); else n_pass++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (iready_a !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", iready_a); else n_pass++;
    n_checks++; if (ovalid_a !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", ovalid_a); else n_pass++;
    send(16'd3, 1'b1);
    n_checks++; if (sum_a !== 32'd3) $display("FAIL bp_next_sum: got %0d want 3", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd1) $display("FAIL bp_next_count: got %0d want 1", cnt_a); else n_pass++;
    close_group();
  endtask

  task automatic test_single();
    send(16'hFFFF, 1'b1);
    n_checks++; if (sum_a !== 32'hFFFFFFFF) $display("FAIL single_sum: got %0h want ffffffff", sum_a); else n_pass++;
    n_checks++; if (cnt_a !== 8'd1) $display("FAIL single_count: got %0d want 1", cnt_a); else n_pass++;
    n_checks++; if (ovalid_a !== 1'b1) $display("FAIL single_valid: got %0b want 1", ovalid_a); else n_pass++;
    close_group();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_sum16;
    logic        exp_sat16;
`ifdef MULT_ACC_SAT_EN
    exp_sum16 = 16'h7FFF;
    exp_sat16 = 1'b1;
`else
    exp_sum16 = 16'h8000;
    exp_sat16 = 1'b0;
`endif
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b1);
    n_checks++; if (sum_b !== exp_sum16) $display("FAIL ovf16_sum: got %0h want %0h", sum_b, exp_sum16); else n_pass++;
    n_checks++; if (sat_b !== exp_sat16) $display("FAIL ovf16_sat: got %0b want %0b", sat_b, exp_sat16); else n_pass++;
    n_checks++; if (cnt_b !== 8'd2) $display("FAIL ovf16_count: got %0d want 2", cnt_b); else n_pass++;
    n_checks++; if (sum_a !== 32'd32768) $display("FAIL ovf32_sum: got %0d want 32768", sum_a); else n_pass++;
    n_checks++; if (sat_a !== 1'b0) $display("FAIL ovf32_sat: got %0b want 0", sat_a); else n_pass++;
    close_group();
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 5; i++) begin
      send(16'd1, (i == 4) ? 1'b1 : 1'b0);
    end
    n_checks++; if (cnt_c !== 2'd3) $display("FAIL cnt2_count: got %0d want 3", cnt_c); else n_pass++;
    n_checks++; if (sum_c !== 32'd5) $display("FAIL cnt2_sum: got %0d want 5", sum_c); else n_pass++;
    n_checks++; if (cnt_a !== 8'd5) $display("FAIL cnt8_count: got %0d want 5", cnt_a); else n_pass++;
    // Sticky flag must have cleared after the previous overflowed group.
    n_checks++; if (sat_b !== 1'b0) $display("FAIL acc16_sat_cleared: got %0b want 0", sat_b); else n_pass++;
    n_checks++; if (sum_b !== 16'd5) $display("FAIL acc16_sum_after: got %0d want 5", sum_b); else n_pass++;
    close_group();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = 16'd0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    test_reset();
    test_max_positive();
    test_backpressure();
    test_single();
    test_overflow();
    test_count_sat();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult8s_product_accumulator.md
# mult8s_product_accumulator

Downstream consumer of the registered signed 8x8 multiplier stage. It accepts a stream of 16-bit signed products under a valid/ready handshake and sign-extends each one into a wide accumulator. A producer-marked `in_last` closes each group, and the block then presents the group sum and product count on an output handshake. It is the first multi-cycle stage in the multiplier evaluation datapath and turns single products into dot-product results.

## Interface
Parameters:
- `PROD_W`, 16: product width, two's complement.
- `ACC_W`, 32: accumulator and result width. Must be ≥ `PROD_W`.
- `CNT_W`, 8: product-count width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: product valid.
- `in_ready`, output, 1: block can accept a product.
- `in_product`, input, `PROD_W`: signed product.
- `in_last`, input, 1: this product closes the group. Qualified by `in_valid`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, `ACC_W`: signed group sum.
- `out_count`, output, `CNT_W`: number of products in the group, saturating.
- `out_sat`, output, 1: accumulator clamped during this group.

## Operation
- The FSM has two states, ACC and DONE. Reset state is ACC.
- ACC state:
  - `in_ready` = 1 and `out_valid` = 0.
  - A transfer occurs when `in_valid` && `in_ready`.
  - On a transfer: acc ← acc + sign_ext(`in_product`) and cnt ← cnt + 1. cnt saturates at 2^`CNT_W`−1 and does not wrap.
  - On a transfer with `in_last` = 1: the updated acc and cnt are latched into `out_sum` and `out_count`, then the FSM moves to DONE.
- DONE state:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_sum`, `out_count` and `out_sat` stay stable until `out_ready` = 1.
  - On `out_valid` && `out_ready`: acc, cnt and the sat flag clear, and the FSM returns to ACC.
- A single-product group (`in_last` on the first transfer) is legal and gives `out_count` = 1.
- `in_valid` asserted while `in_ready` = 0 is ignored. The producer holds the product until it is accepted.
- Reset mid-group discards the partial acc. Reset in DONE drops the pending result.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_sat` = 0. Internal acc, cnt and sat flag = 0.
- Latency: the cycle of the `in_last` transfer is cycle N, and `out_valid` rises at cycle N+1.
- `out_ready` held high: the handshake completes in cycle N+1, and `in_ready` returns at N+2. This gives one bubble per group.
- Steady throughput is one product per cycle inside a group.
- Outputs are registered. There is no combinational path from `in_*` to `out_*`. `in_ready` depends only on state, never on `out_ready`.

## Configuration
- Macro: `MULT_ACC_SAT_EN`.
- Defined:
  - An addition that overflows signed `ACC_W` clamps acc to 2^(`ACC_W`−1)−1 or −2^(`ACC_W`−1).
  - The sticky sat flag is set and reported on `out_sat`.
  - Later additions continue from the clamped value.
- Undefined:
  - Two's-complement wrap-around.
  - `out_sat` is tied 0.
  - The sat flag and the clamp logic are not compiled.

## Structure
- Package `mult_acc_pkg` holds:
  - the state enum (ACC, DONE);
  - the default width constants `PROD_W`, `ACC_W` and `CNT_W`;
  - the function for the signed saturating add.
- Sub-module `mult_acc_sat_add` is natural: a combinational `ACC_W` adder with overflow detect and clamp. It is instantiated once, and the clamp is bypassed when the macro is undefined.
- Top-level wrappers in this flow register the `mult8s` operands and product and add no reset; this block supplies the stage's own reset.

## Test plan
- **Reset:** assert `rst` mid-group after 3 products → all outputs 0 and `in_ready` = 1. A following group of {5, 7} with `in_last` on 7 → `out_sum` = 12, `out_count` = 2.
- **Max positive products:** 4 products of 16384 (−128×−128), last on the 4th → `out_sum` = 65536, `out_count` = 4, `out_valid` exactly 1 cycle after the last transfer.
- **Backpressure:**
  - Group {−32512, 1}: hold `out_ready` = 0 for 5 cycles → `out_sum` = −32511 stable, `in_ready` = 0 throughout, and `in_valid` pulses are ignored.
  - Then release `out_ready` → `in_ready` = 1 the next cycle.
- **Single-product group:** product −1 with `in_last` → `out_sum` = all ones (−1), `out_count` = 1.
- **Overflow, `ACC_W` = 16:** {16384, 16384} → with `MULT_ACC_SAT_EN`, `out_sum` = 32767 and `out_sat` = 1. Without the macro, `out_sum` = −32768 and `out_sat` = 0.
- **Count saturation, `CNT_W` = 2:** 5 products of 1 → `out_count` = 3, `out_sum` = 5.
